// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with a 2-entry skid buffer, flush bubble insert
// and an optional saturating stall counter enabled by STALL_CNT_EN.
module pipe_stage_skid_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);
    // encoding doubles as {main_v, skid_v}
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
    state_t state, state_n;
    logic [CTRL_W-1:0] main_c, skid_c;
    logic [DATA_W-1:0] main_d, skid_d;
    logic main_v, skid_v, it, ot, load_main, load_skid, skid_to_main;
    assign main_v    = state[1];
    assign skid_v    = state[0];
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_c : '0;
    assign out_data  = main_d;
    assign it        = in_valid & in_ready;
    assign ot        = main_v & out_ready;
    always_comb begin
        state_n      = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                load_main = it;
                state_n   = it ? ONE : EMPTY;
            end
            ONE: begin
                load_main = it & ot;
                load_skid = it & !ot;
                state_n   = (it & !ot) ? FULL : (ot & !it) ? EMPTY : ONE;
            end
            FULL: begin
                skid_to_main = ot;
                state_n      = ot ? ONE : FULL;
            end
            default: state_n = EMPTY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_c <= '0;
            main_d <= '0;
            skid_c <= '0;
            skid_d <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            main_c <= '0;
            skid_c <= '0;
        end else begin
            state <= state_n;
            if (load_main) begin
                main_c <= in_ctrl;
                main_d <= in_data;
            end else if (skid_to_main) begin
                main_c <= skid_c;
                main_d <= skid_d;
            end
            if (load_skid) begin
                skid_c <= in_ctrl;
                skid_d <= in_data;
            end
        end
    end
`ifdef STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (main_v && !out_ready && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: randomized and directed checks of pipe_stage_skid_reg against a
// queue-based reference model of the stage contents.
module tb_pipe_stage_skid_reg;
    localparam int CW = 8;
    localparam int DW = 128;
    logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [CW+DW-1:0] q[$];
    int vec = 0, miss = 0;
    int c16 = 0, c2 = 0;
    bit it_last;
    always #5 clk = ~clk;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [1:0] stall_cnt2;
    logic u2_ir, u2_ov;
    logic [CW-1:0] u2_oc;
    logic [DW-1:0] u2_od;
    pipe_stage_skid_reg #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(u2_ir),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(u2_ov), .out_ready(out_ready),
        .out_ctrl(u2_oc), .out_data(u2_od), .stall_cnt(stall_cnt2));
`endif
    pipe_stage_skid_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [CW+1:0] exp_sig();
        return {q.size() > 0, q.size() < 2, q.size() > 0 ? q[0][CW+DW-1:DW] : {CW{1'b0}}};
    endfunction

    function automatic logic [DW-1:0] exp_d();
        return q.size() > 0 ? q[0][DW-1:0] : '0;
    endfunction

    // advance one clock and apply the stage rules to the model queue
    task automatic tick();
        bit ot, st;
        @(posedge clk);
        it_last = in_valid && q.size() < 2;
        ot = q.size() > 0 && out_ready;
        st = q.size() > 0 && !out_ready;
        if (rst) begin
            q.delete();
            c16 = 0;
            c2 = 0;
        end else begin
            if (st && c16 < 65535) c16++;
            if (st && c2 < 3) c2++;
            if (flush) q.delete();
            else begin
                if (ot) void'(q.pop_front());
                if (it_last) q.push_back({in_ctrl, in_data});
            end
        end
        #1;
    endtask

    task automatic put(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl = c;
        in_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        put(8'hFF, {4{$urandom}});
        out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        in_valid = 1'b0;
        vec++;
        if ({out_valid, in_ready, out_ctrl} !== {2'b01, 8'h00} || out_data !== '0) begin
            miss++;
            $display("FAIL reset: got v=%b r=%b c=%h d=%h, want v=0 r=1 c=00 d=0", out_valid, in_ready, out_ctrl, out_data);
        end
`ifdef STALL_CNT_EN
        vec++;
        if (stall_cnt !== 16'd0) begin
            miss++;
            $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
`endif
        tick();
        vec++;
        if ({out_valid, in_ready, out_ctrl} !== {2'b01, 8'h00}) begin
            miss++;
            $display("FAIL idle: got v=%b r=%b c=%h, want v=0 r=1 c=00", out_valid, in_ready, out_ctrl);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) put(CW'(i), DW'(i));
            else in_valid = 1'b0;
            tick();
            vec++;
            if ({out_valid, in_ready, out_ctrl} !== exp_sig() || (out_valid && out_data !== exp_d())) begin
                miss++;
                $display("FAIL stream %0d: got v=%b r=%b c=%h d=%h, want %b/%h", i, out_valid, in_ready, out_ctrl, out_data, exp_sig(), exp_d());
            end
            if (i <= 8) begin
                vec++;
                if (!out_valid || out_ctrl !== CW'(i) || out_data !== DW'(i)) begin
                    miss++;
                    $display("FAIL stream_order %0d: got v=%b c=%h d=%h, want v=1 c=%h d=%h", i, out_valid, out_ctrl, out_data, i, i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        put(8'h11, DW'('h11));
        tick();
        put(8'h22, DW'('h22));
        tick();
        put(8'h33, DW'('h33));
        repeat (3) begin
            tick();
            vec++;
            if (in_ready !== 1'b0 || it_last || out_data !== DW'('h11) || out_ctrl !== 8'h11) begin
                miss++;
                $display("FAIL bp_hold: got r=%b c=%h d=%h, want r=0 c=11 d=11", in_ready, out_ctrl, out_data);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (it_last) in_valid = 1'b0;
            tick();
            vec++;
            if ({out_valid, in_ready, out_ctrl} !== exp_sig() || (out_valid && out_data !== exp_d())) begin
                miss++;
                $display("FAIL bp_drain %0d: got v=%b r=%b c=%h d=%h, want %b/%h", i, out_valid, in_ready, out_ctrl, out_data, exp_sig(), exp_d());
            end
        end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        put(8'h0A, DW'('hA));
        tick();
        put(8'h0B, DW'('hB));
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec++;
        if ({out_valid, in_ready, out_ctrl} !== {2'b01, 8'h00}) begin
            miss++;
            $display("FAIL flush_full: got v=%b r=%b c=%h, want v=0 r=1 c=00", out_valid, in_ready, out_ctrl);
        end
        put(8'h44, DW'('h44));
        tick();
        in_valid = 1'b0;
        vec++;
        if (!out_valid || out_ctrl !== 8'h44 || out_data !== DW'('h44)) begin
            miss++;
            $display("FAIL flush_new: got v=%b c=%h d=%h, want v=1 c=44 d=44", out_valid, out_ctrl, out_data);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush_input();
        out_ready = 1'b0;
        put(8'h01, DW'('h1));
        tick();
        put(8'h55, DW'('h55));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            vec++;
            if ({out_valid, in_ready, out_ctrl} !== {2'b01, 8'h00}) begin
                miss++;
                $display("FAIL flush_in: got v=%b r=%b c=%h, want v=0 r=1 c=00", out_valid, in_ready, out_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_stall_cnt();
`ifdef STALL_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        put(8'h66, DW'('h66));
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        vec++;
        if (stall_cnt !== 16'd5 || c16 != 5) begin
            miss++;
            $display("FAIL stall5: got %0d want 5", stall_cnt);
        end
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vec++;
        if (stall_cnt !== 16'd5) begin
            miss++;
            $display("FAIL stall_flush: got %0d want 5", stall_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++;
        if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
            miss++;
            $display("FAIL stall_rst: got %0d/%0d want 0/0", stall_cnt, stall_cnt2);
        end
        out_ready = 1'b0;
        put(8'h77, DW'('h77));
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        vec++;
        if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd6) begin
            miss++;
            $display("FAIL stall_sat: got %0d/%0d want 3/6", stall_cnt2, stall_cnt);
        end
        out_ready = 1'b1;
        tick();
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(63) == 0);
            flush = ($urandom_range(15) == 0);
            out_ready = ($urandom_range(3) != 0);
            in_valid = ($urandom_range(3) != 0);
            in_ctrl = CW'($urandom);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            vec++;
            if ({out_valid, in_ready, out_ctrl} !== exp_sig() || (out_valid && out_data !== exp_d())) begin
                miss++;
                $display("FAIL random %0d: got v=%b r=%b c=%h d=%h, want %b/%h", i, out_valid, in_ready, out_ctrl, out_data, exp_sig(), exp_d());
            end
`ifdef STALL_CNT_EN
            vec++;
            if (stall_cnt !== 16'(c16) || stall_cnt2 !== 2'(c2)) begin
                miss++;
                $display("FAIL random_cnt %0d: got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt2, c16, c2);
            end
`endif
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_input();
        test_stall_cnt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
